// File: rtl/hilo_mult_ctrl_if.sv
// -----------------------------------------------------------------------------
// hilo_mult_ctrl_if
// Bundle of the signals between the HI/LO multiply controller, the EX stage of
// the pipeline and the iterative shift-add Multiplier.
//
//   Pipeline side : start, op, dataA, dataB      -> controller
//                   rd_data, hi, lo, busy, stall, done <- controller
//   Multiplier    : mul_reset, mul_signal, mul_a, mul_b <- controller
//                   mul_product                          -> controller
//
// modport slave  : the controller itself
// modport master : the environment (pipeline + Multiplier)
// -----------------------------------------------------------------------------
interface hilo_mult_ctrl_if;
    logic        start;
    logic [5:0]  op;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        mul_reset;
    logic [5:0]  mul_signal;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_product;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall;
    logic        done;

    modport slave (
        input  start, op, dataA, dataB, mul_product,
        output mul_reset, mul_signal, mul_a, mul_b,
        output hi, lo, rd_data, busy, stall, done
    );

    modport master (
        output start, op, dataA, dataB, mul_product,
        input  mul_reset, mul_signal, mul_a, mul_b,
        input  hi, lo, rd_data, busy, stall, done
    );
endinterface

// File: rtl/hilo_mult_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_mult_ctrl
// Sequencing controller for the iterative shift-add Multiplier and owner of the
// architectural HI/LO registers.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : hilo_mult_ctrl_if.slave
//            start/op/dataA/dataB  EX-stage instruction and operands
//            mul_reset/mul_signal/mul_a/mul_b  Multiplier control and operands
//            mul_product           Multiplier 64-bit result
//            hi/lo                 architectural HI and LO
//            rd_data               MFHI/MFLO result (valid when stall==0)
//            busy                  multiply operation in flight
//            stall                 hold EX and earlier stages
//            done                  one-cycle pulse after HI/LO update
//
// Sequence for one MULT/MADDU: IDLE -> CLR (Multiplier cleared) -> RUN
// (ITER+1 cycles: load + ITER iterations) -> CAPT (HI:LO written) -> IDLE.
// -----------------------------------------------------------------------------
module hilo_mult_ctrl #(
    parameter int          ITER     = 32,
    parameter logic [5:0]  OP_MULT  = 6'b011001,
    parameter logic [5:0]  OP_MADDU = 6'b000001,
    parameter logic [5:0]  OP_MFHI  = 6'b010000,
    parameter logic [5:0]  OP_MFLO  = 6'b010010,
    parameter logic [5:0]  OP_IDLE  = 6'b111111
) (
    input  logic             clk,
    input  logic             reset,
    hilo_mult_ctrl_if.slave  bus
);

    localparam int                CNT_W    = $clog2(ITER + 1) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CLR  = 2'b01,
        S_RUN  = 2'b10,
        S_CAPT = 2'b11
    } state_t;

    state_t            state_q;
    logic [5:0]        op_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic              done_q;

    logic              busy_s;
    logic              accept_s;
    logic [63:0]       hilo_d;
    logic [5:0]        mul_signal_s;
    logic [31:0]       rd_data_s;

    // True for the two opcodes that start a Multiplier operation.
    function automatic logic is_mul_op(input logic [5:0] f);
        return (f == OP_MULT) || (f == OP_MADDU);
    endfunction

    // True for every opcode that touches HI/LO and must wait for a busy unit.
    function automatic logic is_hilo_op(input logic [5:0] f);
        return is_mul_op(f) || (f == OP_MFHI) || (f == OP_MFLO);
    endfunction

    // Accept decision and the HI:LO value written in CAPT (overwrite or 64-bit
    // accumulate; the carry out of bit 63 is dropped by the 64-bit sum).
    always_comb begin
        busy_s   = (state_q != S_IDLE);
        accept_s = bus.start && is_mul_op(bus.op) && (state_q == S_IDLE);
        if (op_q == OP_MULT) begin
            hilo_d = bus.mul_product;
        end else begin
            hilo_d = {hi_q, lo_q} + bus.mul_product;
        end
    end

    // Multiplier Signal: the latched opcode only while iterating, park otherwise.
    always_comb begin
        mul_signal_s = OP_IDLE;
        case (state_q)
            S_RUN:   mul_signal_s = op_q;
            S_IDLE:  mul_signal_s = OP_IDLE;
            S_CLR:   mul_signal_s = OP_IDLE;
            S_CAPT:  mul_signal_s = OP_IDLE;
            default: mul_signal_s = OP_IDLE;
        endcase
    end

    // MFHI/MFLO read port; HI/LO are already updated in the done cycle.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (bus.op == OP_MFHI) begin
            rd_data_s = hi_q;
        end else if (bus.op == OP_MFLO) begin
            rd_data_s = lo_q;
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    // Sequencing FSM, operand latches, iteration counter, HI/LO and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 6'b000000;
            a_q     <= 32'h0000_0000;
            b_q     <= 32'h0000_0000;
            cnt_q   <= '0;
            hi_q    <= 32'h0000_0000;
            lo_q    <= 32'h0000_0000;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        op_q    <= bus.op;
                        a_q     <= bus.dataA;
                        b_q     <= bus.dataB;
                        state_q <= S_CLR;
                    end
                end
                S_CLR: begin
                    cnt_q   <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    // cnt runs 0..ITER, so RUN lasts ITER+1 cycles.
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    hi_q    <= hilo_d[63:32];
                    lo_q    <= hilo_d[31:0];
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Multiplier is held in reset both by the system reset and during CLR.
    assign bus.mul_reset  = reset || (state_q == S_CLR);
    assign bus.mul_signal = mul_signal_s;
    assign bus.mul_a      = a_q;
    assign bus.mul_b      = b_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.rd_data    = rd_data_s;
    assign bus.busy       = busy_s;
    assign bus.stall      = bus.start && busy_s && is_hilo_op(bus.op);
    assign bus.done       = done_q;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_mult_ctrl
// Scoreboard bench: stimulus pushes expected HI:LO values (per operation) and
// expected rd_data values (per MFHI/MFLO) into queues; a monitor pops and
// compares on every done pulse and every non-stalled MFHI/MFLO.
// The Multiplier is modelled as a unit that only yields A*B after exactly
// ITER+1 cycles of non-idle Signal following a clear; otherwise it yields junk.
// -----------------------------------------------------------------------------
module tb_hilo_mult_ctrl;

    localparam logic [5:0] OP_MULT  = 6'b011001;
    localparam logic [5:0] OP_MADDU = 6'b000001;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_IDLE  = 6'b111111;
    localparam logic [5:0] OP_NONE  = 6'b000000;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_UNK   = 6'b111110;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [63:0] exp_hl_q [$];
    logic [31:0] exp_rd_q [$];

    hilo_mult_ctrl_if bus();

    hilo_mult_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: counts Signal-active cycles since the last clear.
    logic [6:0] mcnt;
    always @(posedge clk or posedge reset) begin
        if (reset) mcnt <= 7'd0;
        else if (bus.mul_reset) mcnt <= 7'd0;
        else if (bus.mul_signal != OP_IDLE && mcnt != 7'd127) mcnt <= mcnt + 7'd1;
    end
    assign bus.mul_product = (mcnt == 7'd33) ? (64'(bus.mul_a) * 64'(bus.mul_b))
                                             : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare HI:LO on done, rd_data on each accepted MFHI/MFLO.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done) begin
                if (exp_hl_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    check("hilo", {bus.hi, bus.lo}, exp_hl_q.pop_front());
                end
            end
            if (bus.start && (bus.op == OP_MFHI || bus.op == OP_MFLO) && !bus.stall) begin
                if (exp_rd_q.size() == 0) begin
                    check("unexpected_rd", 64'd1, 64'd0);
                end else begin
                    check("rd_data", {32'd0, bus.rd_data}, {32'd0, exp_rd_q.pop_front()});
                end
            end
        end
    end

    // Issue one MULT/MADDU and follow it to the done cycle (returns at that negedge).
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        int busy_n = 0;
        int rst_n_cnt = 0;
        int sig_n = 0;
        #1;
        exp_hl_q.push_back(exp);
        bus.start = 1'b1; bus.op = f; bus.dataA = a; bus.dataB = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = OP_NONE;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            busy_n++;
            if (bus.mul_reset) rst_n_cnt++;
            if (bus.mul_signal == f) sig_n++;
        end
        check("busy_cycles", 64'(busy_n), 64'd35);
        check("mul_reset_cycles", 64'(rst_n_cnt), 64'd1);
        check("signal_cycles", 64'(sig_n), 64'd33);
        check("done_in_idle", {63'd0, bus.done}, 64'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = OP_NONE; bus.dataA = 32'd0; bus.dataB = 32'd0;

        // Reset state
        @(negedge clk);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_mul_reset", {63'd0, bus.mul_reset}, 64'd1);
        check("rst_signal", {58'd0, bus.mul_signal}, {58'd0, OP_IDLE});
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mul_reset_idle", {63'd0, bus.mul_reset}, 64'd0);

        // MULT 3*5, then MADDU 0xFFFFFFFF*2: 15 + 0x1_FFFFFFFE = 0x2_0000000D
        run_op(OP_MULT, 32'd3, 32'd5, 64'h0000_0000_0000_000F);
        @(negedge clk);
        check("done_single", {63'd0, bus.done}, 64'd0);
        run_op(OP_MADDU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0002_0000_000D);

        // Stall window: MULT 0x10000*0x30001 = 0x3_00010000
        #1;
        exp_hl_q.push_back(64'h0000_0003_0001_0000);
        bus.start = 1'b1; bus.op = OP_MULT; bus.dataA = 32'h0001_0000; bus.dataB = 32'h0003_0001;
        @(posedge clk); #1;
        bus.op = OP_ADD;
        @(negedge clk);
        check("nonhilo_no_stall", {62'd0, bus.busy, bus.stall}, 64'd2);
        @(posedge clk); #1;
        exp_rd_q.push_back(32'h0001_0000);
        bus.op = OP_MFLO;
        begin
            int held = 0;
            int bad  = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (!bus.busy) break;
                held++;
                if (!bus.stall) bad++;
            end
            check("stall_held", 64'(bad), 64'd0);
            check("stall_cycles", 64'(held), 64'd34);
        end
        check("release_stall", {63'd0, bus.stall}, 64'd0);
        #1;
        exp_rd_q.push_back(32'h0000_0003);
        bus.op = OP_MFHI;
        @(negedge clk);
        #1;
        bus.op = OP_UNK;
        @(negedge clk);
        check("unk_no_stall", {63'd0, bus.stall}, 64'd0);
        @(negedge clk);
        check("unk_no_busy", {63'd0, bus.busy}, 64'd0);
        #1 bus.start = 1'b0; bus.op = OP_NONE;
        @(negedge clk);

        // Back-to-back: 6*6, then 7*9 issued in the done cycle
        run_op(OP_MULT, 32'd6, 32'd6, 64'd36);
        run_op(OP_MULT, 32'd7, 32'd9, 64'd63);

        // Reset in RUN at cnt=10: abandoned, HI/LO cleared, no done
        #1;
        bus.start = 1'b1; bus.op = OP_MULT; bus.dataA = 32'h1234_5678; bus.dataB = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = OP_NONE;
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_mul_reset", {63'd0, bus.mul_reset}, 64'd1);
        @(posedge clk); #1 reset = 1'b0;
        begin
            int dn = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.done) dn++;
            end
            check("abort_no_done", 64'(dn), 64'd0);
        end
        run_op(OP_MULT, 32'd2, 32'd2, 64'd4);

        // Accumulate wrap: build all-ones, then +1*1 wraps to zero
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op(OP_MADDU, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(OP_MADDU, 32'd1, 32'd1, 64'd0);
        @(negedge clk);
        @(negedge clk);

        check("hl_queue_empty", 64'(exp_hl_q.size()), 64'd0);
        check("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
